// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-memory port, the hazard/branch control
// inputs and the IF/ID pipeline register outputs of the fetch stage.
//   master : the fetch stage (drives I_addr and the if_* fields)
//   slave  : memory plus the decode, hazard and branch units
// Signals:
//   I_addr         instruction address to memory (combinational)
//   I_data         memory byte for the address presented in the previous cycle
//   stall          hold PC and IF/ID contents
//   flush          kill IF/ID contents and any half-assembled instruction
//   redirect_valid load the PC from redirect_pc
//   redirect_pc    redirect target
//   if_valid       IF/ID holds a real instruction
//   if_instr       opcode byte
//   if_imm         immediate byte (0 for one-byte instructions)
//   if_len         1 = two-byte instruction
//   if_pc          address of the opcode byte
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] I_addr;
  logic [DATA_WIDTH-1:0] I_data;
  logic                  stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [DATA_WIDTH-1:0] if_imm;
  logic                  if_len;
  logic [ADDR_WIDTH-1:0] if_pc;

  modport master (
    output I_addr, if_valid, if_instr, if_imm, if_len, if_pc,
    input  I_data, stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  I_addr, if_valid, if_instr, if_imm, if_len, if_pc,
    output I_data, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 8-bit pipelined processor.
// Issues addresses to a memory with a one-cycle registered read, assembles
// one-byte and two-byte (opcode + immediate) instructions and presents them
// through the registered IF/ID outputs, under stall, flush and redirect control.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (memory port, control inputs, IF/ID outputs)
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 8'h00,
  parameter logic [3:0]            LONG_OP    = 4'hC
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic {
    ST_OP,   // next valid byte is an opcode
    ST_IMM   // next valid byte is the immediate of op_hold
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] op_hold_q, op_hold_d;
  logic [ADDR_WIDTH-1:0] op_pc_q, op_pc_d;

  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [DATA_WIDTH-1:0] if_imm_q, if_imm_d;
  logic                  if_len_q, if_len_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  is_long;

  // Wraps modulo 2^ADDR_WIDTH, so an opcode at the top address takes its
  // immediate from address 0.
  assign pc_inc  = pc_q + ADDR_WIDTH'(1);
  assign is_long = (bus.I_data[DATA_WIDTH-1 -: 4] == LONG_OP);

  // While stalled, re-present the in-flight address so the memory returns the
  // same byte again and nothing is lost when the stall releases.
  assign bus.I_addr = bus.stall ? last_addr_q : pc_q;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    op_hold_d  = op_hold_q;
    op_pc_d    = op_pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_imm_d   = if_imm_q;
    if_len_d   = if_len_q;
    if_pc_d    = if_pc_q;

    if (bus.redirect_valid) begin
      // The byte arriving next cycle belongs to the old path.
      pc_d       = bus.redirect_pc;
      rd_valid_d = 1'b0;
      state_d    = ST_OP;
      if_valid_d = 1'b0;
    end else if (bus.flush) begin
      pc_d       = pc_inc;
      rd_valid_d = 1'b0;
      state_d    = ST_OP;
      if_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = pc_inc;
      rd_valid_d = 1'b1;
      if (!rd_valid_q) begin
        if_valid_d = 1'b0;
      end else if (state_q == ST_IMM) begin
        if_valid_d = 1'b1;
        if_instr_d = op_hold_q;
        if_imm_d   = bus.I_data;
        if_len_d   = 1'b1;
        if_pc_d    = op_pc_q;
        state_d    = ST_OP;
      end else if (is_long) begin
        op_hold_d  = bus.I_data;
        op_pc_d    = last_addr_q;
        state_d    = ST_IMM;
        if_valid_d = 1'b0;
      end else begin
        if_valid_d = 1'b1;
        if_instr_d = bus.I_data;
        if_imm_d   = '0;
        if_len_d   = 1'b0;
        if_pc_d    = last_addr_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pending-opcode registers are reset too, so a reset taken in
      // the middle of a two-byte instruction leaves no stale state behind.
      pc_q        <= RESET_PC;
      last_addr_q <= RESET_PC;
      state_q     <= ST_OP;
      rd_valid_q  <= 1'b0;
      op_hold_q   <= '0;
      op_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_imm_q    <= '0;
      if_len_q    <= 1'b0;
      if_pc_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      last_addr_q <= bus.I_addr;
      state_q     <= state_d;
      rd_valid_q  <= rd_valid_d;
      op_hold_q   <= op_hold_d;
      op_pc_q     <= op_pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_imm_q    <= if_imm_d;
      if_len_q    <= if_len_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_imm   = if_imm_q;
  assign bus.if_len   = if_len_q;
  assign bus.if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. A registered memory model
// feeds I_data; a transaction-level model predicts the IF/ID outputs from the
// memory contents and the control inputs, and is compared every cycle.
// Directed scenarios additionally pin hand-computed literal outputs.
module tb_fetch_stage;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [AW-1:0] RESET_PC = 8'h00;
  localparam logic [3:0]    LONG_OP  = 4'hC;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  fetch_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_stage #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RESET_PC), .LONG_OP(LONG_OP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) bus.I_data <= mem[bus.I_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // m_next: next address fetch will request. m_fly_*: which address's byte is
  // usable this cycle. m_have/m_op/m_op_pc: an opcode awaiting its immediate.
  logic [AW-1:0] m_next, m_fly_a, m_op_pc;
  logic          m_fly_v, m_have;
  logic [DW-1:0] m_op;
  logic          e_v, e_len;
  logic [DW-1:0] e_instr, e_imm;
  logic [AW-1:0] e_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_next <= RESET_PC; m_fly_v <= 1'b0; m_fly_a <= '0;
      m_have <= 1'b0; m_op <= '0; m_op_pc <= '0;
      e_v <= 1'b0; e_instr <= '0; e_imm <= '0; e_len <= 1'b0; e_pc <= '0;
    end else if (bus.redirect_valid) begin
      m_next <= bus.redirect_pc; m_fly_v <= 1'b0; m_have <= 1'b0; e_v <= 1'b0;
    end else if (bus.flush) begin
      m_next <= m_next + 8'd1; m_fly_v <= 1'b0; m_have <= 1'b0; e_v <= 1'b0;
    end else if (!bus.stall) begin
      m_fly_v <= 1'b1;
      m_fly_a <= m_next;
      m_next  <= m_next + 8'd1;
      if (!m_fly_v) begin
        e_v <= 1'b0;
      end else if (m_have) begin
        e_v <= 1'b1; e_instr <= m_op; e_imm <= mem[m_fly_a];
        e_len <= 1'b1; e_pc <= m_op_pc; m_have <= 1'b0;
      end else if (mem[m_fly_a][7:4] == LONG_OP) begin
        m_have <= 1'b1; m_op <= mem[m_fly_a]; m_op_pc <= m_fly_a; e_v <= 1'b0;
      end else begin
        e_v <= 1'b1; e_instr <= mem[m_fly_a]; e_imm <= '0;
        e_len <= 1'b0; e_pc <= m_fly_a;
      end
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_if_valid", bus.if_valid, e_v);
      if (e_v) begin
        check("m_if_instr", bus.if_instr, e_instr);
        check("m_if_imm",   bus.if_imm,   e_imm);
        check("m_if_len",   bus.if_len,   e_len);
        check("m_if_pc",    bus.if_pc,    e_pc);
      end
      if (!bus.stall) check("m_I_addr", bus.I_addr, m_next);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load_prog_a();
    logic [DW-1:0] prog [7];
    prog = '{8'h10, 8'h11, 8'hC2, 8'h22, 8'h13, 8'h14, 8'h15};
    clear_mem();
    for (int i = 0; i < 7; i++) mem[i] = prog[i];
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_valid"}, bus.if_valid, 0);
    check({tag, "_instr"}, bus.if_instr, 0);
    check({tag, "_imm"},   bus.if_imm,   0);
    check({tag, "_len"},   bus.if_len,   0);
    check({tag, "_pc"},    bus.if_pc,    0);
    check({tag, "_addr"},  bus.I_addr,   RESET_PC);
  endtask

  task automatic do_reset();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    rst_n = 1'b0;
    #1 zero_check("rst");
    #1 rst_n = 1'b1;
  endtask

  // Literal expectation of the IF/ID outputs.
  task automatic expect_out(input string name, input logic v, input logic [7:0] instr,
                            input logic [7:0] imm, input logic len, input logic [7:0] pc);
    check({name, "_valid"}, bus.if_valid, v);
    if (v) begin
      check({name, "_instr"}, bus.if_instr, instr);
      check({name, "_imm"},   bus.if_imm,   imm);
      check({name, "_len"},   bus.if_len,   len);
      check({name, "_pc"},    bus.if_pc,    pc);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    clear_mem();
    #2;

    // Sequential one-byte instructions after reset.
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    do_reset();
    tick(); expect_out("t1_e1", 0, 0, 0, 0, 0);
    tick(); expect_out("t1_b0", 1, 8'h12, 0, 0, 8'h00);
    tick(); expect_out("t1_b1", 1, 8'h34, 0, 0, 8'h01);
    tick(); expect_out("t1_b2", 1, 8'h56, 0, 0, 8'h02);

    // Two-byte instruction then a one-byte one.
    clear_mem();
    mem[0] = 8'hC5; mem[1] = 8'hAA; mem[2] = 8'h01;
    do_reset();
    tick(); expect_out("t2_e1", 0, 0, 0, 0, 0);
    tick(); expect_out("t2_op", 0, 0, 0, 0, 0);
    tick(); expect_out("t2_long", 1, 8'hC5, 8'hAA, 1, 8'h00);
    tick(); expect_out("t2_next", 1, 8'h01, 0, 0, 8'h02);

    // Stall for 3 cycles in OP, then 3 cycles in IMM.
    load_prog_a();
    do_reset();
    tick(); tick(); tick(); expect_out("t3_pre", 1, 8'h11, 0, 0, 8'h01);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_out("t3_hold_op", 1, 8'h11, 0, 0, 8'h01); end
    bus.stall = 1'b0;
    tick(); expect_out("t3_op", 0, 0, 0, 0, 0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_out("t3_hold_imm", 0, 0, 0, 0, 0); end
    bus.stall = 1'b0;
    tick(); expect_out("t3_long", 1, 8'hC2, 8'h22, 1, 8'h02);
    tick(); expect_out("t3_n1", 1, 8'h13, 0, 0, 8'h04);
    tick(); expect_out("t3_n2", 1, 8'h14, 0, 0, 8'h05);

    // Redirect while in IMM, then redirect coinciding with a stall.
    load_prog_a();
    mem[8'h40] = 8'h5A; mem[8'h41] = 8'h5B;
    do_reset();
    tick(); tick(); tick(); tick(); expect_out("t4_imm", 0, 0, 0, 0, 0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40;
    tick(); expect_out("t4_bub1", 0, 0, 0, 0, 0);
    bus.redirect_valid = 1'b0;
    tick(); expect_out("t4_bub2", 0, 0, 0, 0, 0);
    tick(); expect_out("t4_tgt", 1, 8'h5A, 0, 0, 8'h40);
    tick(); expect_out("t4_tgt1", 1, 8'h5B, 0, 0, 8'h41);
    bus.redirect_valid = 1'b1; bus.stall = 1'b1;
    tick(); expect_out("t4s_bub1", 0, 0, 0, 0, 0);
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    tick(); expect_out("t4s_bub2", 0, 0, 0, 0, 0);
    tick(); expect_out("t4s_tgt", 1, 8'h5A, 0, 0, 8'h40);

    // Wrap-around through 8'hFF with a two-byte instruction at the top.
    clear_mem();
    mem[0] = 8'h99; mem[1] = 8'h01; mem[8'hFE] = 8'h07; mem[8'hFF] = 8'hC1;
    do_reset();
    tick(); tick(); expect_out("t5_first", 1, 8'h99, 0, 0, 8'h00);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hFE;
    tick(); bus.redirect_valid = 1'b0;
    tick(); expect_out("t5_bub", 0, 0, 0, 0, 0);
    tick(); expect_out("t5_fe", 1, 8'h07, 0, 0, 8'hFE);
    tick(); expect_out("t5_op", 0, 0, 0, 0, 0);
    tick(); expect_out("t5_ff", 1, 8'hC1, 8'h99, 1, 8'hFF);
    tick(); expect_out("t5_01", 1, 8'h01, 0, 0, 8'h01);

    // Flush while in IMM drops the pending opcode.
    load_prog_a();
    do_reset();
    tick(); tick(); tick(); tick();
    bus.flush = 1'b1;
    tick(); expect_out("t6_f1", 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    tick(); expect_out("t6_f2", 0, 0, 0, 0, 0);
    tick(); expect_out("t6_n1", 1, 8'h14, 0, 0, 8'h05);
    tick(); expect_out("t6_n2", 1, 8'h15, 0, 0, 8'h06);

    // Short asynchronous reset pulse while in IMM, away from any clock edge.
    load_prog_a();
    do_reset();
    tick(); tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1 zero_check("t7_async");
    #1 rst_n = 1'b1;
    tick(); expect_out("t7_e1", 0, 0, 0, 0, 0);
    tick(); expect_out("t7_b0", 1, 8'h10, 0, 0, 8'h00);
    tick(); expect_out("t7_b1", 1, 8'h11, 0, 0, 8'h01);
    tick(); expect_out("t7_op", 0, 0, 0, 0, 0);
    tick(); expect_out("t7_long", 1, 8'hC2, 8'h22, 1, 8'h02);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
